// File: rtl/ras_stack.sv
// Return address stack: push on predicted calls, pop on predicted returns, checkpoint/repair on mispredict; next-cycle visibility, no backpressure.
// Optional RAS_REPAIR_EN adds ckpt_top_o/recover_top_i so recovery also rewrites the restored top entry.
module ras_stack #(
    parameter int RAS_DEPTH       = 16,
    parameter int RAS_PTR_W       = 4,
    parameter int RAS_PUSH_OFFSET = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 predict_valid_i,
    input  logic                 predict_is_call_i,
    input  logic                 predict_is_return_i,
    input  logic [31:0]          predict_pc_i,
    output logic                 ras_valid_o,
    output logic [31:0]          ras_target_o,
    output logic [RAS_PTR_W-1:0] ckpt_ptr_o,
    output logic [RAS_PTR_W:0]   ckpt_count_o,
`ifdef RAS_REPAIR_EN
    output logic [31:0]          ckpt_top_o,
`endif
    input  logic                 recover_valid_i,
    input  logic [RAS_PTR_W-1:0] recover_ptr_i,
    input  logic [RAS_PTR_W:0]   recover_count_i,
`ifdef RAS_REPAIR_EN
    input  logic [31:0]          recover_top_i,
`endif
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam logic [RAS_PTR_W:0]   CNT_FULL = (RAS_PTR_W+1)'(RAS_DEPTH);
    localparam logic [RAS_PTR_W:0]   CNT_ONE  = (RAS_PTR_W+1)'(1);
    localparam logic [RAS_PTR_W-1:0] PTR_ONE  = RAS_PTR_W'(1);

    logic [31:0]          stack_q [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] tos_q, tos_d;
    logic [RAS_PTR_W:0]   count_q, count_d;
    logic                 wr_en;
    logic [RAS_PTR_W-1:0] wr_idx;
    logic [31:0]          wr_dat;
    logic                 ovf_d, unf_d;
    logic [31:0]          ret_addr;
    logic [31:0]          top_dat;

    assign ret_addr = predict_pc_i + 32'(RAS_PUSH_OFFSET);
    assign top_dat  = stack_q[tos_q];

    assign ras_valid_o  = (count_q != '0);
    assign ras_target_o = top_dat;
    assign ckpt_ptr_o   = tos_q;
    assign ckpt_count_o = count_q;
`ifdef RAS_REPAIR_EN
    assign ckpt_top_o   = top_dat;
`endif

    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tos_q;
        wr_dat  = ret_addr;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (recover_valid_i) begin
            tos_d   = recover_ptr_i;
            count_d = recover_count_i;
`ifdef RAS_REPAIR_EN
            wr_en   = 1'b1;
            wr_idx  = recover_ptr_i;
            wr_dat  = recover_top_i;
`endif
        end else if (predict_valid_i) begin
            case ({predict_is_call_i, predict_is_return_i})
                2'b10: begin
                    // A full stack keeps its count; the write lands on the oldest slot.
                    wr_en  = 1'b1;
                    wr_idx = tos_q + PTR_ONE;
                    tos_d  = tos_q + PTR_ONE;
                    if (count_q == CNT_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (count_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d   = tos_q - PTR_ONE;
                        count_d = count_q - CNT_ONE;
                    end
                end
                2'b11: begin
                    // Pop-then-push collapses to replacing the top in place.
                    wr_en  = 1'b1;
                    wr_idx = tos_q;
                    if (count_q == '0) begin
                        count_d = CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos_q       <= '0;
            count_q     <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_o  <= ovf_d;
            underflow_o <= unf_d;
            if (wr_en) begin
                stack_q[wr_idx] <= wr_dat;
            end
        end
    end

endmodule

// File: tb/tb_ras_stack.sv
// Directed plus randomized bench for ras_stack against a queue-free array model of stack semantics.
module tb_ras_stack;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        predict_valid, predict_is_call, predict_is_return;
    logic [31:0] predict_pc;
    logic        ras_valid;
    logic [31:0] ras_target;
    logic [3:0]  ckpt_ptr;
    logic [4:0]  ckpt_count;
    logic        recover_valid;
    logic [3:0]  recover_ptr;
    logic [4:0]  recover_count;
    logic        overflow, underflow;
`ifdef RAS_REPAIR_EN
    logic [31:0] ckpt_top;
    logic [31:0] recover_top;
`endif

    always #5 clk = ~clk;

    ras_stack #(.RAS_DEPTH(16), .RAS_PTR_W(4), .RAS_PUSH_OFFSET(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .predict_valid_i     (predict_valid),
        .predict_is_call_i   (predict_is_call),
        .predict_is_return_i (predict_is_return),
        .predict_pc_i        (predict_pc),
        .ras_valid_o         (ras_valid),
        .ras_target_o        (ras_target),
        .ckpt_ptr_o          (ckpt_ptr),
        .ckpt_count_o        (ckpt_count),
`ifdef RAS_REPAIR_EN
        .ckpt_top_o          (ckpt_top),
`endif
        .recover_valid_i     (recover_valid),
        .recover_ptr_i       (recover_ptr),
        .recover_count_i     (recover_count),
`ifdef RAS_REPAIR_EN
        .recover_top_i       (recover_top),
`endif
        .overflow_o          (overflow),
        .underflow_o         (underflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: top index, occupancy and entry contents of a circular stack.
    logic [31:0] m_stk [D];
    int          m_tos, m_cnt;
    bit          m_ovf, m_unf;
    int          ck_tos, ck_cnt;
    logic [31:0] ck_top;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_stk[i] = '0;
        m_tos = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step(input bit rv, input int rp, input int rc, input logic [31:0] rt,
                              input bit pv, input bit c, input bit r, input logic [31:0] pc);
        logic [31:0] ra;
        ra = pc + 32'd4;
        m_ovf = 0; m_unf = 0;
        if (rv) begin
            m_tos = rp; m_cnt = rc;
`ifdef RAS_REPAIR_EN
            m_stk[rp] = rt;
`endif
        end else if (pv && c && !r) begin
            m_tos = (m_tos + 1) % D;
            m_stk[m_tos] = ra;
            if (m_cnt == D) m_ovf = 1; else m_cnt = m_cnt + 1;
        end else if (pv && r && !c) begin
            if (m_cnt == 0) m_unf = 1;
            else begin m_tos = (m_tos + D - 1) % D; m_cnt = m_cnt - 1; end
        end else if (pv && c && r) begin
            m_stk[m_tos] = ra;
            if (m_cnt == 0) m_cnt = 1;
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(ras_valid), 32'(m_cnt != 0));
        chk("target", ras_target, m_stk[m_tos]);
        chk("ckpt_ptr", 32'(ckpt_ptr), 32'(m_tos));
        chk("ckpt_count", 32'(ckpt_count), 32'(m_cnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef RAS_REPAIR_EN
        chk("ckpt_top", ckpt_top, m_stk[m_tos]);
`endif
    endtask

    task automatic cyc(input bit rv, input int rp, input int rc, input logic [31:0] rt,
                       input bit pv, input bit c, input bit r, input logic [31:0] pc);
        recover_valid = rv; recover_ptr = 4'(rp); recover_count = 5'(rc);
`ifdef RAS_REPAIR_EN
        recover_top = rt;
`endif
        predict_valid = pv; predict_is_call = c; predict_is_return = r; predict_pc = pc;
        model_step(rv, rp, rc, rt, pv, c, r, pc);
        @(posedge clk);
        #1;
        recover_valid = 0; predict_valid = 0; predict_is_call = 0; predict_is_return = 0;
        @(negedge clk);
        check_all();
    endtask

    task automatic push(input logic [31:0] pc); cyc(0, 0, 0, '0, 1, 1, 0, pc); endtask
    task automatic pop();                       cyc(0, 0, 0, '0, 1, 0, 1, '0); endtask
    task automatic idle();                      cyc(0, 0, 0, '0, 0, 0, 0, '0); endtask
    task automatic save_ckpt();
        ck_tos = m_tos; ck_cnt = m_cnt; ck_top = m_stk[m_tos];
    endtask
    task automatic recover_ck(); cyc(1, ck_tos, ck_cnt, ck_top, 0, 0, 0, '0); endtask

    initial begin
        predict_valid = 0; predict_is_call = 0; predict_is_return = 0; predict_pc = '0;
        recover_valid = 0; recover_ptr = '0; recover_count = '0;
`ifdef RAS_REPAIR_EN
        recover_top = '0;
`endif
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1;
        @(negedge clk);
        check_all();

        // Basic push/pop.
        push(32'h1000);
        push(32'h2000);
        chk("basic_top2", ras_target, 32'h2004);
        chk("basic_cnt2", 32'(ckpt_count), 32'd2);
        pop();
        chk("basic_pop1", ras_target, 32'h1004);
        pop();
        chk("basic_empty", 32'(ras_valid), 32'd0);

        // Overflow: 17 pushes into a 16-deep stack, then drain.
        for (int k = 1; k <= 17; k++) push(32'(32'h100 * k));
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(ckpt_count), 32'd16);
        idle();
        chk("ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("drain_top", ras_target, 32'(32'h100 * (17 - i) + 4));
            pop();
        end
        chk("drain_empty", 32'(ras_valid), 32'd0);

        // Underflow.
        pop();
        chk("unf_pulse", 32'(underflow), 32'd1);
        idle();
        chk("unf_clear", 32'(underflow), 32'd0);

        // Reset mid-operation with a push in flight.
        predict_valid = 1; predict_is_call = 1; predict_pc = 32'h9000;
        #2 rst_n = 0;
        #1 model_reset();
        chk("async_rst_valid", 32'(ras_valid), 32'd0);
        chk("async_rst_ptr", 32'(ckpt_ptr), 32'd0);
        @(posedge clk);
        #1 predict_valid = 0; predict_is_call = 0;
        @(negedge clk);
        check_all();
        rst_n = 1;

        // Checkpoint and wrong-path recovery.
        push(32'h1000);
        push(32'h2000);
        save_ckpt();
        chk("ck_ptr", 32'(ckpt_ptr), 32'd2);
        chk("ck_top", ras_target, 32'h2004);
        push(32'h3000);
        recover_ck();
        chk("rec_clean", ras_target, 32'h2004);
        pop();
        push(32'h3000);
        recover_ck();
`ifdef RAS_REPAIR_EN
        chk("rec_overwrite", ras_target, 32'h2004);
`else
        chk("rec_overwrite", ras_target, 32'h3004);
`endif

        // Co-routine call+return.
        pop();
        chk("co_pre", ras_target, 32'h1004);
        cyc(0, 0, 0, '0, 1, 1, 1, 32'h5000);
        chk("co_top", ras_target, 32'h5004);
        chk("co_cnt", 32'(ckpt_count), 32'd1);
        pop();
        cyc(0, 0, 0, '0, 1, 1, 1, 32'h5100);
        chk("co_empty_cnt", 32'(ckpt_count), 32'd1);

        // Recovery beats a simultaneous push.
        save_ckpt();
        push(32'h6000);
        cyc(1, ck_tos, ck_cnt, ck_top, 1, 1, 0, 32'h7000);
        chk("rec_vs_push_ptr", 32'(ckpt_ptr), 32'(ck_tos));
        chk("rec_vs_push_cnt", 32'(ckpt_count), 32'(ck_cnt));

        // Return address wrap.
        push(32'hFFFF_FFFC);
        chk("wrap", ras_target, 32'h0);

        // Randomized traffic.
        save_ckpt();
        for (int n = 0; n < 600; n++) begin
            int sel;
            logic [31:0] pc;
            sel = int'($urandom_range(0, 99));
            pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 7) == 0) save_ckpt();
            if (sel < 6) cyc(1, ck_tos, ck_cnt, ck_top, 1'($urandom), 1'($urandom), 1'($urandom), pc);
            else if (sel < 45) push(pc);
            else if (sel < 85) pop();
            else if (sel < 92) cyc(0, 0, 0, '0, 1, 1, 1, pc);
            else cyc(0, 0, 0, '0, 1'($urandom), 0, 0, pc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return Address Stack in the branch-predictor cluster, directly downstream of the BTB.
- Consumes the BTB's per-lookup call/return flags. Pushes the return address on predicted calls and supplies the predicted target on predicted returns.
- Fetch redirect logic uses the returned target in place of the BTB target whenever the BTB hit is flagged as a return.
- Provides a per-prediction checkpoint so branch resolution can repair speculative corruption.

Parameters:
RAS_DEPTH, 16, number of stack entries (power of two, >=2)
RAS_PTR_W, 4, log2(RAS_DEPTH)
RAS_PUSH_OFFSET, 4, byte offset added to the call PC to form the return address

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
predict_valid_i  input  1  BTB lookup hit accepted by fetch this cycle
predict_is_call_i  input  1  hit entry is a call (push)
predict_is_return_i  input  1  hit entry is a return (pop)
predict_pc_i  input  32  PC of the predicted call/return instruction
ras_valid_o  output  1  stack non-empty; ras_target_o meaningful
ras_target_o  output  32  current top-of-stack address (combinational read)
ckpt_ptr_o  output  RAS_PTR_W  current top pointer, carried with the branch
ckpt_count_o  output  RAS_PTR_W+1  current occupancy, carried with the branch
ckpt_top_o  output  32  current top entry (present only with RAS_REPAIR_EN)
recover_valid_i  input  1  misprediction repair request from branch resolution
recover_ptr_i  input  RAS_PTR_W  checkpointed pointer to restore
recover_count_i  input  RAS_PTR_W+1  checkpointed occupancy to restore
recover_top_i  input  32  checkpointed top entry (present only with RAS_REPAIR_EN)
overflow_o  output  1  one-cycle pulse: push overwrote the oldest entry
underflow_o  output  1  one-cycle pulse: pop attempted on empty stack

Behaviour:
- State: circular array stack[0..RAS_DEPTH-1], pointer tos (indexes the top valid entry), occupancy count in 0..RAS_DEPTH.
- Reset, asynchronous: tos=0, count=0, all entries=0, overflow_o=0, underflow_o=0. Consequently ras_valid_o=0, ras_target_o=0 and ckpt outputs are 0.
- Combinational outputs:
  - ras_target_o = stack[tos]; ras_valid_o = (count!=0).
  - ckpt_ptr_o = tos; ckpt_count_o = count; ckpt_top_o = stack[tos].
  - All reflect state before this cycle's update.
- Return address: predict_pc_i + RAS_PUSH_OFFSET, modulo 2^32 (wraps, no carry out).
- Pointer arithmetic is modulo RAS_DEPTH. tos+1 and tos-1 wrap naturally in RAS_PTR_W bits.
- Per-cycle action, priority order:
  1. recover_valid_i: tos<=recover_ptr_i; count<=recover_count_i. All predict inputs are ignored that cycle; overflow_o and underflow_o are 0.
  2. predict_valid_i with call only (push): stack[tos+1]<=return address; tos<=tos+1; count<=min(count+1,RAS_DEPTH). If count was RAS_DEPTH, the oldest entry is overwritten and overflow_o=1 next cycle.
  3. predict_valid_i with return only (pop): if count>0, tos<=tos-1 and count<=count-1. If count==0, tos and count are unchanged and underflow_o=1 next cycle.
  4. predict_valid_i with both call and return (co-routine jump): pop-then-push. stack[tos]<=return address; tos unchanged; count<=max(count,1); no overflow or underflow pulse.
  5. predict_valid_i with neither flag, or predict_valid_i=0: no state change.
- Latency: a push or pop is visible on ras_target_o one cycle later. Back-to-back push/pop every cycle is supported.
- overflow_o and underflow_o are registered and deassert the cycle after any cycle in which they were not set.
- Popped entries are not cleared. This allows pointer-only recovery to re-expose them.
- Reset asserted mid-operation clears all state immediately, regardless of in-flight predict or recover.

Optional Feature:
- Macro: RAS_REPAIR_EN.
- Defined:
  - ckpt_top_o and recover_top_i exist.
  - On recover_valid_i, stack[recover_ptr_i]<=recover_top_i in addition to the pointer/count restore. This repairs a top entry clobbered by a wrong-path push.
- Undefined:
  - Neither port exists; recovery restores tos and count only.
  - A wrong-path push followed by recovery may leave a corrupted entry at the restored tos.

Test Plan:
- Reset, then push at PC 0x1000, then at PC 0x2000 -> ras_target_o=0x2004, count=2; pop -> ras_target_o=0x1004 next cycle; pop -> ras_valid_o=0.
- 17 pushes at PC 0x100*k (k=1..17), RAS_DEPTH=16 -> overflow_o pulses once after the 17th; count=16; 16 pops return 0x1104 down to 0x204.
- Pop on empty stack -> underflow_o=1 for exactly one cycle; tos and count unchanged; ras_valid_o=0.
- Checkpoint (tos=2, count=2, top=0x2004), wrong-path push at PC 0x3000, then recover with checkpoint -> ras_target_o=0x2004 with RAS_REPAIR_EN. Without the feature, ras_target_o=0x2004 only if no wrong-path push overwrote index 2; cover the overwrite case via push-after-pop.
- Call+return same cycle with top=0x1004 and PC 0x5000 -> ras_target_o=0x5004, count unchanged. recover_valid_i asserted together with a push -> push ignored; state equals the checkpoint.
- Push at PC 0xFFFFFFFC -> ras_target_o=0x00000000 (address wrap).
